boron_key_schedule: RTL and testbench
=====================================

Name: boron_key_schedule

Overview:
Sequential BORON key schedule that sits directly upstream of the round-function stage (round-key XOR, S-box layer, permutation layer) and supplies its 64-bit key input.
- Loads a master key (80- or 128-bit) and produces the NUM_ROUNDS+1 round keys one at a time, in order.
- Uses a valid/next handshake driven by the round controller.
- Reuses the existing 4-bit s_box cell for the nibble-substitution step.

Parameters:
KEY_WIDTH, 80, master key width; legal values 80 or 128; any other value is an elaboration error
NUM_ROUNDS, 25, cipher rounds; the block emits NUM_ROUNDS+1 round keys, including final whitening

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_rst  input  1  synchronous, active-high reset
i_ks_load  input  1  capture i_ks_key and start a new schedule
i_ks_key  input  KEY_WIDTH  master key, sampled only when i_ks_load=1
i_ks_next  input  1  consumer accepted the current round key; advance
o_ks_round_key  output  64  current round key, K[63:0]
o_ks_valid  output  1  o_ks_round_key is meaningful
o_ks_round  output  5  index of the current round key, 1..NUM_ROUNDS+1; 0 when idle
o_ks_last  output  1  current key is the final whitening key (round NUM_ROUNDS+1)
o_ks_busy  output  1  schedule in progress (state ACTIVE)

Behaviour:
- Reset values: key register 0, state IDLE, o_ks_valid=0, o_ks_round=0, o_ks_last=0, o_ks_busy=0, o_ks_round_key=0.
- State machine: IDLE, ACTIVE, DONE.
  - IDLE or DONE + i_ks_load -> ACTIVE.
  - ACTIVE + i_ks_next with o_ks_last=1 -> DONE.
  - i_rst from any state -> IDLE, including mid-schedule; the partial schedule is discarded.
- Load:
  - Cycle after i_ks_load=1: K=i_ks_key, o_ks_round=1, o_ks_valid=1, o_ks_round_key=i_ks_key[63:0].
  - Load latency is 1 cycle.
  - i_ks_load in ACTIVE restarts immediately; it has priority over a simultaneous i_ks_next.
- Update on i_ks_next in ACTIVE with o_ks_last=0, moving from round r to r+1:
  - Step 1: K = K rotated left by 13 over KEY_WIDTH bits.
  - Step 2: K[3:0] = S(K[3:0]). For KEY_WIDTH=128, also K[7:4] = S(K[7:4]).
  - Step 3: K[63:59] ^= r[4:0].
  - Then o_ks_round=r+1. The new key is visible the next cycle (1-cycle latency, one update per cycle max).
- i_ks_next is ignored when o_ks_valid=0 (IDLE or DONE).
- o_ks_last = (state==ACTIVE && o_ks_round==NUM_ROUNDS+1), registered.
- DONE: o_ks_valid=0, o_ks_busy=0. o_ks_round and o_ks_round_key hold their last values unless zeroize is enabled.
- Round counter is 5 bits, so NUM_ROUNDS+1 must be ≤ 31; this is checked at elaboration.
- i_ks_key changes outside a load cycle have no effect.

Optional Feature:
BORON_KS_ZEROIZE_EN
- Defined: on entry to DONE, and on reset, the key register and o_ks_round_key are cleared to 0 in the same cycle the state changes. o_ks_round returns to 0.
- Undefined: the key register retains its final value in DONE.

Decomposition:
- Package boron_pkg holds:
  - ROUND_KEY_WIDTH=64, KS_ROTATE=13, RC_MSB=63, RC_LSB=59, RC_WIDTH=5
  - state enum ks_state_t {IDLE, ACTIVE, DONE}
- Sub-module: the existing s_box, instantiated once (KEY_WIDTH=80) or twice (KEY_WIDTH=128) in a generate on the rotated key's low nibbles. No new sub-module.

Test Plan:
- Reset mid-run: load, 3 nexts, assert i_rst -> next cycle all outputs 0, state IDLE; a subsequent i_ks_next does nothing.
- 80-bit zero key: load 80'h0 -> round 1 key 64'h0000000000000000, valid=1; one next -> round 2 key 64'h080000000000000E (S(0)=E, rc=1 at bit 59).
- Full sequence, NUM_ROUNDS=25: load any key, pulse next each cycle -> rounds 1..26 in order; o_ks_last high only at round 26; next at round 26 -> valid=0, busy=0.
- Simultaneous load+next at round 10 -> the next cycle shows round 1 with the new key; the next pulse is dropped.
- Stall: hold next low 5 cycles at round 4 -> key and round stable; one next -> round 5 matches the golden model; back-to-back nexts match the golden model for all rounds.
- KEY_WIDTH=128, zero key: one next -> round 2 key 64'h08000000000000EE; with BORON_KS_ZEROIZE_EN, the key is 0 the cycle after the final next.

Source files
------------

// File: rtl/boron_key_schedule_pkg.sv
// Purpose: shared constants and state encoding for the BORON key schedule.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package boron_pkg;

    localparam int ROUND_KEY_WIDTH = 64;
    localparam int KS_ROTATE       = 13;
    localparam int RC_MSB          = 63;
    localparam int RC_LSB          = 59;
    localparam int RC_WIDTH        = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } ks_state_t;

endpackage

// File: rtl/boron_key_schedule_if.sv
// Purpose: load/next handshake and round-key bus between round controller and key schedule.
// Latency: n/a (wires only).
// Backpressure: consumer holds i_ks_next low to stall; the current key is held until accepted.
// Modports: master = round controller (drives load/key/next), slave = key schedule.
interface boron_key_schedule_if
    import boron_pkg::*;
#(
    parameter int KEY_WIDTH = 80
);
    logic                       i_ks_load;
    logic [KEY_WIDTH-1:0]       i_ks_key;
    logic                       i_ks_next;
    logic [ROUND_KEY_WIDTH-1:0] o_ks_round_key;
    logic                       o_ks_valid;
    logic [RC_WIDTH-1:0]        o_ks_round;
    logic                       o_ks_last;
    logic                       o_ks_busy;

    modport master (
        output i_ks_load, i_ks_key, i_ks_next,
        input  o_ks_round_key, o_ks_valid, o_ks_round, o_ks_last, o_ks_busy
    );

    modport slave (
        input  i_ks_load, i_ks_key, i_ks_next,
        output o_ks_round_key, o_ks_valid, o_ks_round, o_ks_last, o_ks_busy
    );
endinterface

// File: rtl/s_box.sv
// Purpose: BORON 4-bit substitution cell.
// Latency: combinational.
// Backpressure: n/a.
// Ports: i_nibble (4-bit input), o_nibble (4-bit substituted output).
module s_box (
    input  logic [3:0] i_nibble,
    output logic [3:0] o_nibble
);
    always_comb begin
        o_nibble = 4'h0;
        case (i_nibble)
            4'h0: o_nibble = 4'hE;
            4'h1: o_nibble = 4'h4;
            4'h2: o_nibble = 4'hB;
            4'h3: o_nibble = 4'h1;
            4'h4: o_nibble = 4'h7;
            4'h5: o_nibble = 4'h9;
            4'h6: o_nibble = 4'hC;
            4'h7: o_nibble = 4'hA;
            4'h8: o_nibble = 4'hD;
            4'h9: o_nibble = 4'h2;
            4'hA: o_nibble = 4'h0;
            4'hB: o_nibble = 4'hF;
            4'hC: o_nibble = 4'h8;
            4'hD: o_nibble = 4'h5;
            4'hE: o_nibble = 4'h3;
            4'hF: o_nibble = 4'h6;
            default: o_nibble = 4'h0;
        endcase
    end
endmodule

// File: rtl/boron_key_schedule.sv
// Purpose: sequential BORON key schedule, emits NUM_ROUNDS+1 64-bit round keys in order.
// Latency: 1 cycle from i_ks_load to round 1, 1 cycle per i_ks_next advance.
// Backpressure: key held while i_ks_next is low; next ignored unless o_ks_valid.
// Ports: i_clk, i_rst (sync, active-high), ks (slave modport: load/key/next in, key/valid/round/last/busy out).
// Option: define BORON_KS_ZEROIZE_EN to clear key and round on entry to DONE.
module boron_key_schedule
    import boron_pkg::*;
#(
    parameter int KEY_WIDTH  = 80,
    parameter int NUM_ROUNDS = 25
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    boron_key_schedule_if.slave   ks
);
    // 80-bit keys substitute one nibble per round, 128-bit keys substitute two.
    localparam int NUM_SBOX = (KEY_WIDTH == 128) ? 2 : 1;
    localparam logic [RC_WIDTH-1:0] LAST_ROUND = RC_WIDTH'(NUM_ROUNDS + 1);

    if (KEY_WIDTH != 80 && KEY_WIDTH != 128) begin : g_bad_key_width
        $error("boron_key_schedule: KEY_WIDTH must be 80 or 128");
    end
    if (NUM_ROUNDS < 1 || NUM_ROUNDS + 1 > 31) begin : g_bad_rounds
        $error("boron_key_schedule: NUM_ROUNDS+1 must be in 2..31");
    end

    ks_state_t              state_q, state_d;
    logic [KEY_WIDTH-1:0]   key_q, key_d;
    logic [RC_WIDTH-1:0]    round_q, round_d;
    logic                   last_q, last_d;

    logic [KEY_WIDTH-1:0]   key_rot;
    logic [KEY_WIDTH-1:0]   key_upd;
    logic [3:0]             sb_out [NUM_SBOX];

    assign key_rot = {key_q[KEY_WIDTH-KS_ROTATE-1:0], key_q[KEY_WIDTH-1:KEY_WIDTH-KS_ROTATE]};

    for (genvar g = 0; g < NUM_SBOX; g++) begin : g_sbox
        s_box u_s_box (
            .i_nibble (key_rot[4*g +: 4]),
            .o_nibble (sb_out[g])
        );
    end

    // Rotated key with low nibble(s) substituted, then round counter folded into K[63:59].
    always_comb begin
        key_upd = key_rot;
        for (int j = 0; j < NUM_SBOX; j++) begin
            key_upd[4*j +: 4] = sb_out[j];
        end
        key_upd[RC_MSB:RC_LSB] = key_upd[RC_MSB:RC_LSB] ^ round_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            round_q <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            last_q  <= last_d;
        end
    end

    // Load wins over next so a restart never consumes a stale advance.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        last_d  = last_q;
        if (ks.i_ks_load) begin
            state_d = ACTIVE;
            key_d   = ks.i_ks_key;
            round_d = RC_WIDTH'(1);
            last_d  = (LAST_ROUND == RC_WIDTH'(1));
        end else begin
            unique case (state_q)
                ACTIVE: begin
                    if (ks.i_ks_next) begin
                        if (last_q) begin
                            state_d = DONE;
                            last_d  = 1'b0;
`ifdef BORON_KS_ZEROIZE_EN
                            key_d   = '0;
                            round_d = '0;
`endif
                        end else begin
                            key_d   = key_upd;
                            round_d = round_q + RC_WIDTH'(1);
                            last_d  = ((round_q + RC_WIDTH'(1)) == LAST_ROUND);
                        end
                    end
                end
                IDLE, DONE: begin
                    last_d = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign ks.o_ks_round_key = key_q[ROUND_KEY_WIDTH-1:0];
    assign ks.o_ks_valid     = (state_q == ACTIVE);
    assign ks.o_ks_busy      = (state_q == ACTIVE);
    assign ks.o_ks_round     = round_q;
    assign ks.o_ks_last      = last_q;

endmodule

// File: tb/tb_boron_key_schedule.sv
// Purpose: self-checking bench for boron_key_schedule, 80-bit and 128-bit instances side by side.
// Latency: n/a.
// Backpressure: n/a.
module tb_boron_key_schedule;
    localparam int NR = 25;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ld  = 1'b0;
    logic nx  = 1'b0;
    logic [79:0]  k80  = '0;
    logic [127:0] k128 = '0;

    int checks   = 0;
    int failures = 0;
    bit armed    = 1'b0;

    always #5 clk = ~clk;

    boron_key_schedule_if #(.KEY_WIDTH(80))  if80 ();
    boron_key_schedule_if #(.KEY_WIDTH(128)) if128 ();

    assign if80.i_ks_load  = ld;
    assign if80.i_ks_next  = nx;
    assign if80.i_ks_key   = k80;
    assign if128.i_ks_load = ld;
    assign if128.i_ks_next = nx;
    assign if128.i_ks_key  = k128;

    boron_key_schedule #(.KEY_WIDTH(80), .NUM_ROUNDS(NR)) dut80 (
        .i_clk (clk),
        .i_rst (rst),
        .ks    (if80)
    );

    boron_key_schedule #(.KEY_WIDTH(128), .NUM_ROUNDS(NR)) dut128 (
        .i_clk (clk),
        .i_rst (rst),
        .ks    (if128)
    );

    // Reference model: one entry per instance (0 = 80-bit, 1 = 128-bit).
    logic [3:0]   sbox_tbl [16] = '{4'hE, 4'h4, 4'hB, 4'h1, 4'h7, 4'h9, 4'hC, 4'hA,
                                    4'hD, 4'h2, 4'h0, 4'hF, 4'h8, 4'h5, 4'h3, 4'h6};
    logic [127:0] m_key   [2];
    int           m_round [2];
    bit           m_valid [2];

    function automatic logic [127:0] model_next(logic [127:0] k, int w, int r);
        logic [127:0] n;
        logic [4:0]   rc;
        n = '0;
        for (int i = 0; i < w; i++) n[(i + 13) % w] = k[i];
        for (int j = 0; j < ((w == 128) ? 2 : 1); j++) n[4*j +: 4] = sbox_tbl[n[4*j +: 4]];
        rc = r[4:0];
        for (int b = 0; b < 5; b++) n[59 + b] = n[59 + b] ^ rc[b];
        return n;
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_key[d] = '0; m_round[d] = 0; m_valid[d] = 1'b0;
            end else if (ld) begin
                m_key[d]   = (d == 0) ? {48'h0, k80} : k128;
                m_round[d] = 1;
                m_valid[d] = 1'b1;
            end else if (nx && m_valid[d]) begin
                if (m_round[d] == NR + 1) begin
                    m_valid[d] = 1'b0;
`ifdef BORON_KS_ZEROIZE_EN
                    m_key[d]   = '0;
                    m_round[d] = 0;
`endif
                end else begin
                    m_key[d]   = model_next(m_key[d], (d == 0) ? 80 : 128, m_round[d]);
                    m_round[d] = m_round[d] + 1;
                end
            end
        end
    end

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (armed) begin
            chk("key80",   128'(if80.o_ks_round_key),  {64'h0, m_key[0][63:0]});
            chk("round80", 128'(if80.o_ks_round),      128'(m_round[0]));
            chk("valid80", 128'(if80.o_ks_valid),      128'(m_valid[0]));
            chk("busy80",  128'(if80.o_ks_busy),       128'(m_valid[0]));
            chk("last80",  128'(if80.o_ks_last),       128'(m_valid[0] && m_round[0] == NR + 1));
            chk("key128",  128'(if128.o_ks_round_key), {64'h0, m_key[1][63:0]});
            chk("round128",128'(if128.o_ks_round),     128'(m_round[1]));
            chk("valid128",128'(if128.o_ks_valid),     128'(m_valid[1]));
            chk("last128", 128'(if128.o_ks_last),      128'(m_valid[1] && m_round[1] == NR + 1));
        end
    end

    task automatic cyc(int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic rand_keys();
        k80  = {$urandom(), $urandom(), 16'($urandom())};
        k128 = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic chk_idle_zero(string tag);
        chk({tag, "_key"},   128'(if80.o_ks_round_key), 128'h0);
        chk({tag, "_valid"}, 128'(if80.o_ks_valid),     128'h0);
        chk({tag, "_round"}, 128'(if80.o_ks_round),     128'h0);
        chk({tag, "_last"},  128'(if80.o_ks_last),      128'h0);
        chk({tag, "_busy"},  128'(if80.o_ks_busy),      128'h0);
    endtask

    logic [63:0] new80;

    initial begin
        // Reset state.
        rst = 1'b1;
        cyc(2);
        armed = 1'b1;
        rst = 1'b0;
        chk_idle_zero("reset");

        // Reset mid-run, then a stray next must do nothing.
        rand_keys(); ld = 1'b1; cyc(); ld = 1'b0;
        nx = 1'b1; cyc(3); nx = 1'b0;
        rst = 1'b1; cyc(); rst = 1'b0;
        chk_idle_zero("midrst");
        nx = 1'b1; cyc(); nx = 1'b0;
        chk_idle_zero("idle_next");

        // Zero key: hand-computed first two round keys; then run to completion.
        k80 = '0; k128 = '0; ld = 1'b1; cyc(); ld = 1'b0;
        chk("zero_r1_key",   128'(if80.o_ks_round_key), 128'h0);
        chk("zero_r1_valid", 128'(if80.o_ks_valid),     128'h1);
        chk("zero_r1_round", 128'(if80.o_ks_round),     128'h1);
        nx = 1'b1; cyc();
        chk("zero_r2_key80",  128'(if80.o_ks_round_key),  128'h080000000000000E);
        chk("zero_r2_key128", 128'(if128.o_ks_round_key), 128'h08000000000000EE);
        for (int r = 2; r <= NR; r++) begin
            chk("seq_round", 128'(if80.o_ks_round), 128'(r));
            chk("seq_last",  128'(if80.o_ks_last),  128'h0);
            cyc();
        end
        chk("final_round", 128'(if80.o_ks_round), 128'(NR + 1));
        chk("final_last",  128'(if80.o_ks_last),  128'h1);
        cyc(); nx = 1'b0;
        chk("done_valid", 128'(if80.o_ks_valid), 128'h0);
        chk("done_busy",  128'(if80.o_ks_busy),  128'h0);
`ifdef BORON_KS_ZEROIZE_EN
        chk("done_zero_key",   128'(if128.o_ks_round_key), 128'h0);
        chk("done_zero_round", 128'(if80.o_ks_round),      128'h0);
`else
        chk("done_hold_round", 128'(if80.o_ks_round), 128'(NR + 1));
`endif

        // Load + next together at round 10: load wins, next dropped.
        rand_keys(); ld = 1'b1; cyc(); ld = 1'b0;
        nx = 1'b1; cyc(9);
        chk("pre_restart_round", 128'(if80.o_ks_round), 128'd10);
        rand_keys(); new80 = k80[63:0];
        ld = 1'b1; cyc(); ld = 1'b0; nx = 1'b0;
        chk("restart_round", 128'(if80.o_ks_round),     128'h1);
        chk("restart_key",   128'(if80.o_ks_round_key), 128'(new80));

        // Stall at round 4 for 5 cycles, then advance to the end.
        nx = 1'b1; cyc(3); nx = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_round", 128'(if80.o_ks_round), 128'd4);
            cyc();
        end
        nx = 1'b1; cyc();
        chk("post_stall_round", 128'(if80.o_ks_round), 128'd5);
        cyc(NR); nx = 1'b0;
        chk("post_stall_done", 128'(if80.o_ks_valid), 128'h0);
        cyc();

        // Randomized traffic checked by the compare process.
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            ld  = ($urandom_range(0, 15) == 0);
            nx  = ($urandom_range(0, 3) != 0);
            if (ld) rand_keys();
            else begin
                k80  = {$urandom(), $urandom(), 16'($urandom())};
                k128 = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            cyc();
        end
        rst = 1'b0; ld = 1'b0; nx = 1'b0;
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
